// File: rtl/rsa_param_gen_pkg.sv
// Shared constants and FSM encoding for the rsa parameter generator and the rsa core.
// Pure declarations: no logic, no latency, no flow control.
// Holds the default modulus width and the IDLE/RUN/DONE state encoding.
package rsa_param_gen_pkg;

  localparam int RSA_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rsa_r2_step.sv
// Combinational double-and-conditional-subtract: r_nxt = 2r mod n, for r < n.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module rsa_r2_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH:0]   r_nxt
);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] n_ext;

  // r < n < 2^WIDTH, so doubling always fits in WIDTH+1 bits.
  assign dbl   = r << 1;
  assign n_ext = {1'b0, n};
  assign r_nxt = (dbl >= n_ext) ? (dbl - n_ext) : dbl;

endmodule

// File: rtl/rsa_param_gen.sv
// Derives N_INV = -N^-1 mod 2^WIDTH and R2_MOD_N = 2^(2*WIDTH) mod N bit-serially; optional RSA_PARAM_CACHE_EN.
// Latency: done 2*WIDTH+1 cycles after an accepted start (1 cycle for invalid N or a cache hit).
// Backpressure: start is honoured only in IDLE; starts while busy are dropped, nothing is queued.
module rsa_param_gen
  import rsa_param_gen_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] N_INV,
  output logic [WIDTH-1:0] R2_MOD_N,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH - 1);
  localparam logic [CW-1:0] CNT_INV  = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_nxt;
  logic [CW-1:0]    cnt;
  logic             n_valid;
  logic             accept;
  logic             hit;
  logic [IW-1:0]    idx;

  assign n_valid = N[0] && (N >= WIDTH'(3));
  assign accept  = (state == ST_IDLE) && start;
  assign idx     = cnt[IW-1:0];

`ifdef RSA_PARAM_CACHE_EN
  logic [WIDTH-1:0] last_n;
  logic             last_vld;
  assign hit = last_vld && (N == last_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_n   <= '0;
      last_vld <= 1'b0;
    end else if (accept && !n_valid) begin
      last_vld <= 1'b0;
    end else if (state == ST_RUN && cnt == CNT_LAST) begin
      last_n   <= n_q;
      last_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  rsa_r2_step #(.WIDTH(WIDTH)) u_r2_step (
    .r     (r),
    .n     (n_q),
    .r_nxt (r_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (!n_valid || hit) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      acc      <= '0;
      x        <= '0;
      r        <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      N_INV    <= '0;
      R2_MOD_N <= '0;
    end else if (accept) begin
      n_q <= N;
      err <= !n_valid;
      acc <= WIDTH'(1);
      x   <= '0;
      r   <= (WIDTH + 1)'(1);
      cnt <= '0;
    end else if (state == ST_RUN) begin
      cnt <= cnt + 1'b1;
      r   <= r_nxt;
      // Clearing acc bit i by adding N<<i builds x with N*x + 1 == 0 mod 2^WIDTH.
      if (cnt < CNT_INV && acc[idx]) begin
        acc    <= acc + (n_q << idx);
        x[idx] <= 1'b1;
      end
      if (cnt == CNT_LAST) begin
        N_INV    <= x;
        R2_MOD_N <= r_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rsa_param_gen.sv
// Directed self-checking bench for rsa_param_gen (WIDTH=64), hand-computed expectations.
module tb_rsa_param_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] N = '0;
  logic [63:0] N_INV, R2_MOD_N;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rsa_param_gen #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N),
    .N_INV(N_INV), .R2_MOD_N(R2_MOD_N), .busy(busy), .done(done), .err(err)
  );

  // Pulses start for one cycle and returns negedges from start edge to done (999 on timeout).
  task automatic run(input logic [63:0] n, output int lat);
    @(negedge clk);
    N = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = 999;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({N_INV, R2_MOD_N, busy, done, err} !== 131'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ninv=%h r2=%h busy=%b done=%b err=%b, want all 0",
               N_INV, R2_MOD_N, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_n11();
    int lat;
    run(64'd11, lat);
    n_cmp++;
    if (lat !== 129) begin n_bad++; $display("FAIL n11_latency: got %0d want 129", lat); end
    n_cmp++;
    if (N_INV !== 64'd15092790605762360413) begin
      n_bad++; $display("FAIL n11_ninv: got %0d want 15092790605762360413", N_INV);
    end
    n_cmp++;
    if (R2_MOD_N !== 64'd3) begin n_bad++; $display("FAIL n11_r2: got %0d want 3", R2_MOD_N); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL n11_err: got %b want 0", err); end
    n_cmp++;
    if (64'(64'd11 * N_INV + 64'd1) !== 64'd0) begin
      n_bad++; $display("FAIL n11_inv_prop: N*N_INV+1 = %h want 0", 64'(64'd11 * N_INV + 64'd1));
    end
  endtask

  task automatic test_invalid();
    logic [63:0] bad_n [2];
    int lat;
    bad_n[0] = 64'd10;
    bad_n[1] = 64'd1;
    for (int i = 0; i < 2; i++) begin
      run(bad_n[i], lat);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL inv_latency[%0d]: got %0d want 1", i, lat); end
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err[%0d]: got %b want 1", i, err); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err_held[%0d]: got %b want 1", i, err); end
      n_cmp++;
      if (N_INV !== 64'd15092790605762360413 || R2_MOD_N !== 64'd3) begin
        n_bad++; $display("FAIL inv_keep[%0d]: got ninv=%0d r2=%0d want 15092790605762360413/3",
                          i, N_INV, R2_MOD_N);
      end
    end
  endtask

  task automatic test_edges();
    int lat;
    run(64'd3, lat);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL n3_err_clear: got %b want 0", err); end
    n_cmp++;
    if (N_INV !== 64'h5555555555555555 || R2_MOD_N !== 64'd1) begin
      n_bad++; $display("FAIL n3_vals: got ninv=%h r2=%0d want 5555555555555555/1", N_INV, R2_MOD_N);
    end
    run(64'hFFFFFFFFFFFFFFFF, lat);
    n_cmp++;
    if (N_INV !== 64'd1 || R2_MOD_N !== 64'd1 || lat !== 129) begin
      n_bad++; $display("FAIL nmax_vals: got ninv=%0d r2=%0d lat=%0d want 1/1/129", N_INV, R2_MOD_N, lat);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc = 0;
    int dones = 0;
    int first = 0;
    @(negedge clk);
    N = 64'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 40) begin N = 64'd11; start = 1'b1; end
      if (c == 41) start = 1'b0;
      if (done) begin dones++; if (first == 0) first = c; end
      @(negedge clk);
    end
    n_cmp++;
    if (dones !== 1 || first !== 129) begin
      n_bad++; $display("FAIL busy_start: got dones=%0d first=%0d want 1/129", dones, first);
    end
    n_cmp++;
    if (R2_MOD_N !== 64'd4) begin n_bad++; $display("FAIL n7_r2: got %0d want 4", R2_MOD_N); end
    n_cmp++;
    if (64'(64'd7 * N_INV + 64'd1) !== 64'd0) begin
      n_bad++; $display("FAIL n7_inv_prop: N*N_INV+1 = %h want 0", 64'(64'd7 * N_INV + 64'd1));
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    N = 64'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({N_INV, R2_MOD_N, busy, done, err} !== 131'd0) begin
      n_bad++; $display("FAIL midrun_reset: got ninv=%h r2=%h busy=%b done=%b err=%b want all 0",
                        N_INV, R2_MOD_N, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    run(64'd11, lat);
    n_cmp++;
    if (lat !== 129 || N_INV !== 64'd15092790605762360413 || R2_MOD_N !== 64'd3) begin
      n_bad++; $display("FAIL after_reset_n11: got lat=%0d ninv=%0d r2=%0d want 129/15092790605762360413/3",
                        lat, N_INV, R2_MOD_N);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int want;
`ifdef RSA_PARAM_CACHE_EN
    want = 1;
`else
    want = 129;
`endif
    run(64'd3, lat);
    run(64'd11, lat);
    n_cmp++;
    if (lat !== 129) begin n_bad++; $display("FAIL b2b_first: got %0d want 129", lat); end
    run(64'd11, lat);
    n_cmp++;
    if (lat !== want) begin n_bad++; $display("FAIL b2b_second: got %0d want %0d", lat, want); end
    n_cmp++;
    if (N_INV !== 64'd15092790605762360413 || R2_MOD_N !== 64'd3 || err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_vals: got ninv=%0d r2=%0d err=%b want 15092790605762360413/3/0",
                        N_INV, R2_MOD_N, err);
    end
  endtask

  initial begin
    test_reset();
    test_n11();
    test_invalid();
    test_edges();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
